// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared types and constants for the fetch queue between the fetch stage
//   and the two decode lanes.
//   - if_id_type    : fetch/decode pipeline record
//   - FETCH_WIDTH   : lanes per cycle on both sides of the queue
//   - FQ_DEPTH      : queue depth used by the top level
//   - present_entry : shapes a stored record for presentation to decode
package fetch_queue_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int FQ_DEPTH    = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        predict;
    logic        instr_valid;
  } if_id_type;

  // A lane with no head entry shows an all-zero record; a live lane always
  // carries instr_valid=1 regardless of what fetch wrote into the slot.
  function automatic if_id_type present_entry(input if_id_type entry, input logic valid);
    if_id_type shaped;
    shaped = '0;
    if (valid) begin
      shaped             = entry;
      shaped.instr_valid = 1'b1;
    end
    return shaped;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundle of the fetch-side enqueue and decode-side dequeue signals.
//   master : fetch/decode side (drives in_valid, in_instr, deq_ready)
//   slave  : the queue (drives in_ready, out_valid, out_instr, count)
//   in_valid[1:0]   per-lane fetch valid, lane0 older
//   in_instr[1:0]   fetched records
//   in_ready        queue can take two entries this cycle
//   out_valid[1:0]  head entries present, [1] implies [0]
//   out_instr[1:0]  head (lane0) and head+1 (lane1)
//   deq_ready[1:0]  decode accepts lane, [1] only counts with [0]
//   count           current occupancy
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic      [FETCH_WIDTH-1:0] in_valid;
  if_id_type [FETCH_WIDTH-1:0] in_instr;
  logic                        in_ready;
  logic      [FETCH_WIDTH-1:0] out_valid;
  if_id_type [FETCH_WIDTH-1:0] out_instr;
  logic      [FETCH_WIDTH-1:0] deq_ready;
  logic      [CW-1:0]          count;

  modport master (
    output in_valid, in_instr, deq_ready,
    input  in_ready, out_valid, out_instr, count
  );

  modport slave (
    input  in_valid, in_instr, deq_ready,
    output in_ready, out_valid, out_instr, count
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   2-wide in-order instruction buffer between fetch and the two decode
//   lanes. Circular buffer with show-ahead head presentation; drained by a
//   redirect flush.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high, clears pointers and occupancy
//   flush  : synchronous redirect flush, beats enqueue and dequeue
//   fq     : fetch_queue_if.slave (enqueue, dequeue, in_ready, count)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  fetch_queue_if.slave  fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage has no reset; only the pointers and count define what is live.
  if_id_type mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic                   in_ready;
  logic                   do_enq;
  logic [1:0]             n_enq;
  logic [1:0]             n_deq;
  logic [FETCH_WIDTH-1:0] out_valid;
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [PW-1:0]          wr_addr [FETCH_WIDTH];
  if_id_type              wr_data [FETCH_WIDTH];
  logic [PW-1:0]          rd_addr [FETCH_WIDTH];

  // Always reserve room for a full 2-wide enqueue, judged on the pre-pop
  // occupancy so it depends on registers only.
  assign in_ready = (count_reg <= CW'(DEPTH - 2));

  assign fq.in_ready  = in_ready;
  assign fq.out_valid = out_valid;
  assign fq.count     = count_reg;

  always_comb begin
    do_enq = in_ready && (|fq.in_valid);
    n_enq  = 2'd0;
    if (do_enq) begin
      n_enq = (&fq.in_valid) ? 2'd2 : 2'd1;
    end

    // Lane1 may only pop together with lane0 so decode stays in order.
    n_deq = {1'b0, fq.deq_ready[0] & out_valid[0]}
          + {1'b0, fq.deq_ready[0] & fq.deq_ready[1] & out_valid[1]};

    // Compact the valid lanes: a lone valid lane always lands at wr_ptr.
    wr_en[0]   = do_enq && !flush;
    wr_en[1]   = do_enq && !flush && (&fq.in_valid);
    wr_addr[0] = wr_ptr_reg;
    wr_addr[1] = wr_ptr_reg + PW'(1);
    wr_data[0] = fq.in_valid[0] ? fq.in_instr[0] : fq.in_instr[1];
    wr_data[1] = fq.in_instr[1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) begin
        mem[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  // Show-ahead head presentation; pointer arithmetic wraps modulo DEPTH.
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_head
    assign rd_addr[gi]      = rd_ptr_reg + PW'(gi);
    assign out_valid[gi]    = (count_reg > CW'(gi));
    assign fq.out_instr[gi] = present_entry(mem[rd_addr[gi]], out_valid[gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + PW'(n_deq);
      wr_ptr_reg <= wr_ptr_reg + PW'(n_enq);
      count_reg  <= count_reg + CW'(n_enq) - CW'(n_deq);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue: reset, basic enqueue, fill, streaming
//   with pointer wrap, partial dequeue, near-full, flush, async reset.
module tb_fetch_queue
  import fetch_queue_pkg::*;
;

  logic clk;
  logic reset;
  logic flush;
  int   total;
  int   bad;

  fetch_queue_if #(.DEPTH(FQ_DEPTH)) fq_bus ();

  fetch_queue #(.DEPTH(FQ_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .fq    (fq_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Record as fetch writes it (instr_valid deliberately 0).
  function automatic if_id_type mk(input logic [31:0] ins);
    if_id_type r;
    r.pc          = {ins[29:0], 2'b00};
    r.instruction = ins;
    r.predict     = ins[0];
    r.instr_valid = 1'b0;
    return r;
  endfunction

  // Record as decode must see it.
  function automatic if_id_type shown(input logic [31:0] ins);
    if_id_type r;
    r             = mk(ins);
    r.instr_valid = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    fq_bus.in_valid  = 2'b00;
    fq_bus.in_instr  = '0;
    fq_bus.deq_ready = 2'b00;
    step();
    step();
    reset = 1'b0;
    step();
    total++; if (fq_bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fq_bus.count); end
    total++; if (fq_bus.out_valid !== 2'b00) begin bad++; $display("FAIL reset_out_valid got=%b want=00", fq_bus.out_valid); end
    total++; if (fq_bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", fq_bus.in_ready); end
    total++; if (fq_bus.out_instr !== '0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", fq_bus.out_instr); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    fq_bus.in_valid    = 2'b11;
    fq_bus.in_instr[0] = mk(32'h00500093);
    fq_bus.in_instr[1] = mk(32'h00A00113);
    #1;
    total++; if (fq_bus.out_valid !== 2'b00) begin bad++; $display("FAIL basic_no_bypass got=%b want=00", fq_bus.out_valid); end
    step();
    fq_bus.in_valid = 2'b00;
    total++; if (fq_bus.count !== 4'd2) begin bad++; $display("FAIL basic_count got=%0d want=2", fq_bus.count); end
    total++; if (fq_bus.out_valid !== 2'b11) begin bad++; $display("FAIL basic_out_valid got=%b want=11", fq_bus.out_valid); end
    total++; if (fq_bus.out_instr[0] !== shown(32'h00500093)) begin bad++; $display("FAIL basic_lane0 got=%h want=%h", fq_bus.out_instr[0], shown(32'h00500093)); end
    total++; if (fq_bus.out_instr[1] !== shown(32'h00A00113)) begin bad++; $display("FAIL basic_lane1 got=%h want=%h", fq_bus.out_instr[1], shown(32'h00A00113)); end
    do_flush();
    total++; if (fq_bus.count !== 4'd0) begin bad++; $display("FAIL basic_flush_count got=%0d want=0", fq_bus.count); end
    $display("test_basic done");
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      fq_bus.in_valid    = 2'b11;
      fq_bus.in_instr[0] = mk(32'h100 + 2 * k);
      fq_bus.in_instr[1] = mk(32'h101 + 2 * k);
      total++; if (fq_bus.in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready_%0d got=%b want=1", k, fq_bus.in_ready); end
      step();
      $display("fill cycle=%0d count=%0d", k, fq_bus.count);
    end
    // Upstream holds the next pair while the queue is full.
    fq_bus.in_instr[0] = mk(32'h108);
    fq_bus.in_instr[1] = mk(32'h109);
    total++; if (fq_bus.count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d want=8", fq_bus.count); end
    total++; if (fq_bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b want=0", fq_bus.in_ready); end
    step();
    step();
    total++; if (fq_bus.count !== 4'd8) begin bad++; $display("FAIL fill_hold_count got=%0d want=8", fq_bus.count); end
    total++; if (fq_bus.out_instr[0] !== shown(32'h100)) begin bad++; $display("FAIL fill_head0 got=%h want=%h", fq_bus.out_instr[0], shown(32'h100)); end
    total++; if (fq_bus.out_instr[1] !== shown(32'h101)) begin bad++; $display("FAIL fill_head1 got=%h want=%h", fq_bus.out_instr[1], shown(32'h101)); end
    $display("test_fill done");
  endtask

  task automatic test_stream();
    int  rd_seq;
    int  wr_seq;
    int  exp_count;
    logic exp_ready;
    rd_seq = 32'h100;
    wr_seq = 32'h108;
    fq_bus.deq_ready = 2'b11;
    fq_bus.in_valid  = 2'b11;
    for (int c = 0; c < 20; c++) begin
      exp_count = wr_seq - rd_seq;
      exp_ready = ((8 - exp_count) >= 2);
      fq_bus.in_instr[0] = mk(32'(wr_seq));
      fq_bus.in_instr[1] = mk(32'(wr_seq + 1));
      total++; if (fq_bus.count !== 4'(exp_count)) begin bad++; $display("FAIL stream_count_%0d got=%0d want=%0d", c, fq_bus.count, exp_count); end
      total++; if (fq_bus.in_ready !== exp_ready) begin bad++; $display("FAIL stream_ready_%0d got=%b want=%b", c, fq_bus.in_ready, exp_ready); end
      total++; if (fq_bus.out_instr[0] !== shown(32'(rd_seq))) begin bad++; $display("FAIL stream_lane0_%0d got=%h want=%h", c, fq_bus.out_instr[0], shown(32'(rd_seq))); end
      total++; if (fq_bus.out_instr[1] !== shown(32'(rd_seq + 1))) begin bad++; $display("FAIL stream_lane1_%0d got=%h want=%h", c, fq_bus.out_instr[1], shown(32'(rd_seq + 1))); end
      $display("stream cycle=%0d head=%h count=%0d", c, fq_bus.out_instr[0].instruction, fq_bus.count);
      step();
      if (exp_ready) wr_seq += 2;
      rd_seq += 2;
    end
    fq_bus.in_valid  = 2'b00;
    fq_bus.deq_ready = 2'b00;
    total++; if (fq_bus.count !== 4'(wr_seq - rd_seq)) begin bad++; $display("FAIL stream_end_count got=%0d want=%0d", fq_bus.count, wr_seq - rd_seq); end
    do_flush();
    $display("test_stream done");
  endtask

  task automatic test_partial();
    fq_bus.in_valid    = 2'b11;
    fq_bus.in_instr[0] = mk(32'h200);
    fq_bus.in_instr[1] = mk(32'h201);
    step();
    fq_bus.in_valid    = 2'b10;
    fq_bus.in_instr[0] = mk(32'hBAD);
    fq_bus.in_instr[1] = mk(32'h202);
    step();
    fq_bus.in_valid = 2'b00;
    total++; if (fq_bus.count !== 4'd3) begin bad++; $display("FAIL partial_count3 got=%0d want=3", fq_bus.count); end
    fq_bus.deq_ready = 2'b01;
    step();
    total++; if (fq_bus.count !== 4'd2) begin bad++; $display("FAIL partial_pop1_count got=%0d want=2", fq_bus.count); end
    total++; if (fq_bus.out_instr[1] !== shown(32'h202)) begin bad++; $display("FAIL partial_compact got=%h want=%h", fq_bus.out_instr[1], shown(32'h202)); end
    fq_bus.deq_ready = 2'b10;
    step();
    total++; if (fq_bus.count !== 4'd2) begin bad++; $display("FAIL partial_pop0_count got=%0d want=2", fq_bus.count); end
    total++; if (fq_bus.out_instr[0] !== shown(32'h201)) begin bad++; $display("FAIL partial_pop0_head got=%h want=%h", fq_bus.out_instr[0], shown(32'h201)); end
    fq_bus.deq_ready = 2'b01;
    step();
    total++; if (fq_bus.out_valid !== 2'b01) begin bad++; $display("FAIL partial_one_valid got=%b want=01", fq_bus.out_valid); end
    total++; if (fq_bus.out_instr[1] !== '0) begin bad++; $display("FAIL partial_lane1_zero got=%h want=0", fq_bus.out_instr[1]); end
    fq_bus.deq_ready = 2'b11;
    step();
    total++; if (fq_bus.out_valid !== 2'b00) begin bad++; $display("FAIL partial_drained got=%b want=00", fq_bus.out_valid); end
    step();
    fq_bus.deq_ready = 2'b00;
    total++; if (fq_bus.count !== 4'd0) begin bad++; $display("FAIL partial_empty_pop got=%0d want=0", fq_bus.count); end
    $display("test_partial done");
  endtask

  task automatic test_near_full();
    for (int k = 0; k < 3; k++) begin
      fq_bus.in_valid    = 2'b11;
      fq_bus.in_instr[0] = mk(32'h300 + 2 * k);
      fq_bus.in_instr[1] = mk(32'h301 + 2 * k);
      step();
    end
    fq_bus.in_valid    = 2'b01;
    fq_bus.in_instr[0] = mk(32'h306);
    step();
    total++; if (fq_bus.count !== 4'd7) begin bad++; $display("FAIL near_full_count got=%0d want=7", fq_bus.count); end
    total++; if (fq_bus.in_ready !== 1'b0) begin bad++; $display("FAIL near_full_ready got=%b want=0", fq_bus.in_ready); end
    fq_bus.in_valid    = 2'b11;
    fq_bus.in_instr[0] = mk(32'h307);
    fq_bus.in_instr[1] = mk(32'h308);
    step();
    fq_bus.in_valid  = 2'b00;
    total++; if (fq_bus.count !== 4'd7) begin bad++; $display("FAIL near_full_ignore got=%0d want=7", fq_bus.count); end
    fq_bus.deq_ready = 2'b01;
    step();
    fq_bus.deq_ready = 2'b00;
    total++; if (fq_bus.out_instr[0] !== shown(32'h301)) begin bad++; $display("FAIL near_full_head got=%h want=%h", fq_bus.out_instr[0], shown(32'h301)); end
    total++; if (fq_bus.in_ready !== 1'b1) begin bad++; $display("FAIL near_full_ready6 got=%b want=1", fq_bus.in_ready); end
    do_flush();
    $display("test_near_full done");
  endtask

  task automatic test_flush();
    fq_bus.in_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      fq_bus.in_instr[0] = mk(32'h400 + 2 * k);
      fq_bus.in_instr[1] = mk(32'h401 + 2 * k);
      step();
    end
    fq_bus.in_valid    = 2'b01;
    fq_bus.in_instr[0] = mk(32'h404);
    step();
    total++; if (fq_bus.count !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d want=5", fq_bus.count); end
    flush              = 1'b1;
    fq_bus.in_valid    = 2'b11;
    fq_bus.in_instr[0] = mk(32'h4A0);
    fq_bus.in_instr[1] = mk(32'h4A1);
    fq_bus.deq_ready   = 2'b11;
    step();
    flush            = 1'b0;
    fq_bus.in_valid  = 2'b00;
    fq_bus.deq_ready = 2'b00;
    total++; if (fq_bus.count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", fq_bus.count); end
    total++; if (fq_bus.out_valid !== 2'b00) begin bad++; $display("FAIL flush_out_valid got=%b want=00", fq_bus.out_valid); end
    total++; if (fq_bus.out_instr !== '0) begin bad++; $display("FAIL flush_out_instr got=%h want=0", fq_bus.out_instr); end
    step();
    total++; if (fq_bus.count !== 4'd0) begin bad++; $display("FAIL flush_dropped got=%0d want=0", fq_bus.count); end
    fq_bus.in_valid    = 2'b01;
    fq_bus.in_instr[0] = mk(32'h4B0);
    step();
    fq_bus.in_valid = 2'b00;
    total++; if (fq_bus.out_instr[0] !== shown(32'h4B0)) begin bad++; $display("FAIL flush_restart got=%h want=%h", fq_bus.out_instr[0], shown(32'h4B0)); end
    do_flush();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    fq_bus.in_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      fq_bus.in_instr[0] = mk(32'h500 + 2 * k);
      fq_bus.in_instr[1] = mk(32'h501 + 2 * k);
      step();
    end
    fq_bus.in_valid = 2'b00;
    total++; if (fq_bus.count !== 4'd6) begin bad++; $display("FAIL areset_pre_count got=%0d want=6", fq_bus.count); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (fq_bus.count !== 4'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", fq_bus.count); end
    total++; if (fq_bus.out_valid !== 2'b00) begin bad++; $display("FAIL areset_out_valid got=%b want=00", fq_bus.out_valid); end
    reset              = 1'b0;
    fq_bus.in_valid    = 2'b01;
    fq_bus.in_instr[0] = mk(32'h510);
    step();
    fq_bus.in_valid = 2'b00;
    total++; if (fq_bus.count !== 4'd1) begin bad++; $display("FAIL areset_release_count got=%0d want=1", fq_bus.count); end
    total++; if (fq_bus.out_instr[0] !== shown(32'h510)) begin bad++; $display("FAIL areset_release_head got=%h want=%h", fq_bus.out_instr[0], shown(32'h510)); end
    $display("test_async_reset done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_fill();
    test_stream();
    test_partial();
    test_near_full();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
